// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state codes, opcodes, select codes and the control bundle
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_SHL  = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_retired;
  } ctrl_t;
  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state-to-datapath-control decoder
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_SHL;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write     = 1'b1;
        ctrl.mem_to_reg    = 1'b1;
        ctrl.instr_retired = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write     = 1'b1;
        ctrl.i_or_d        = 1'b1;
        ctrl.instr_retired = mem_ready;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write     = 1'b1;
        ctrl.reg_dst       = 1'b1;
        ctrl.instr_retired = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
        ctrl.instr_retired = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write      = 1'b1;
        ctrl.pc_source     = PC_JUMP;
        ctrl.instr_retired = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write     = 1'b1;
        ctrl.instr_retired = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: main control FSM for the multicycle MIPS datapath
module multicycle_control_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_retired,
  output logic       illegal_op,
  output logic [3:0] state
);
  state_t     state_q, state_d;
  logic [5:0] op_q;
  ctrl_t      c;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
    end
  end
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_FETCH;
        endcase
      S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end
  // During reset the mux selects present FETCH values; enables are gated below
  mc_ctrl_decode u_decode (
    .state    (rst_n ? state_q : S_FETCH),
    .mem_ready(mem_ready),
    .ctrl     (c)
  );
  assign pc_write      = rst_n & c.pc_write;
  assign pc_write_cond = rst_n & c.pc_write_cond;
  assign ir_write      = rst_n & c.ir_write;
  assign reg_write     = rst_n & c.reg_write;
  assign mem_write     = rst_n & c.mem_write;
  assign mem_read      = rst_n & c.mem_read;
  assign instr_retired = rst_n & c.instr_retired;
  assign illegal_op    = rst_n & (state_q == S_DECODE) & ~is_legal(opcode);
  assign i_or_d        = c.i_or_d;
  assign mem_to_reg    = c.mem_to_reg;
  assign reg_dst       = c.reg_dst;
  assign alu_src_a     = c.alu_src_a;
  assign alu_src_b     = c.alu_src_b;
  assign alu_op        = c.alu_op;
  assign pc_source     = c.pc_source;
  assign state         = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed and random stimulus against an instruction-sequence model
module tb_multicycle_control_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       ir_write, reg_dst, reg_write, alu_src_a, instr_retired, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  int         n_vec = 0;
  int         n_bad = 0;
  int         prog[$];
  int         pos;
  logic [5:0] ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  always #5 clk = ~clk;
  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_retired(instr_retired),
    .illegal_op(illegal_op), .state(state)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask
  // Expected outputs written straight from the per-state output list
  function automatic logic [17:0] expect_ctl(input int s, input logic mr, input logic rn, input logic [5:0] op);
    int se;
    logic legal;
    se = rn ? s : 0;
    legal = 1'b0;
    foreach (ops[i]) if (ops[i] == op) legal = 1'b1;
    expect_ctl = {
      rn & ((se == 0 & mr) | se == 9),
      rn & (se == 8),
      (se == 3 | se == 5) ? 1'b1 : 1'b0,
      rn & (se == 0 | se == 3),
      rn & (se == 5),
      (se == 4) ? 1'b1 : 1'b0,
      rn & (se == 0) & mr,
      (se == 7) ? 1'b1 : 1'b0,
      rn & (se == 4 | se == 7 | se == 11),
      (se == 2 | se == 6 | se == 8 | se == 10) ? 1'b1 : 1'b0,
      (se == 0) ? 2'd1 : (se == 1) ? 2'd3 : (se == 2 | se == 10) ? 2'd2 : 2'd0,
      (se == 6) ? 2'd2 : (se == 8) ? 2'd1 : 2'd0,
      (se == 8) ? 2'd1 : (se == 9) ? 2'd2 : 2'd0,
      rn & ((se == 4 | se == 7 | se == 8 | se == 9 | se == 11) | (se == 5 & mr)),
      rn & (se == 1) & ~legal
    };
  endfunction
  task automatic model_edge();
    int s;
    s = prog[pos];
    if (!rst_n) begin
      prog = '{0, 1};
      pos = 0;
    end else if ((s == 0 || s == 3 || s == 5) && !mem_ready) begin
    end else if (s == 1) begin
      case (opcode)
        6'b100011: prog = '{0, 1, 2, 3, 4};
        6'b101011: prog = '{0, 1, 2, 5};
        6'b000000: prog = '{0, 1, 6, 7};
        6'b001000: prog = '{0, 1, 10, 11};
        6'b000100: prog = '{0, 1, 8};
        6'b000010: prog = '{0, 1, 9};
        default:   prog = '{0, 1};
      endcase
      pos = (prog.size() > 2) ? 2 : 0;
    end else begin
      pos++;
      if (pos >= prog.size()) begin
        prog = '{0, 1};
        pos = 0;
      end
    end
  endtask
  task automatic cycle(input logic rn, input logic mr, input logic [5:0] op);
    rst_n = rn;
    mem_ready = mr;
    opcode = op;
    @(negedge clk);
    chk("ctl", {14'd0, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
                ir_write, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                instr_retired, illegal_op},
        {14'd0, expect_ctl(prog[pos], mr, rn, op)});
    chk("state", {28'd0, state}, prog[pos]);
    @(posedge clk);
    model_edge();
    #1;
  endtask
  initial begin
    prog = '{0, 1};
    pos = 0;
    @(posedge clk);
    #1;
    cycle(0, 1, 6'b100011);
    repeat (5) cycle(1, 1, 6'b100011);
    repeat (4) cycle(1, 1, 6'b000000);
    repeat (3) cycle(1, 1, 6'b101011);
    cycle(1, 0, 6'b101011);
    cycle(1, 0, 6'b101011);
    cycle(1, 1, 6'b101011);
    repeat (3) cycle(1, 1, 6'b000100);
    repeat (3) cycle(1, 1, 6'b000010);
    repeat (2) cycle(1, 1, 6'b111111);
    repeat (4) cycle(1, 1, 6'b001000);
    repeat (3) cycle(1, 0, 6'b100011);
    repeat (3) cycle(1, 1, 6'b100011);
    cycle(0, 1, 6'b100011);
    repeat (3) cycle(0, $urandom_range(0, 1), 6'b101011);
    for (int k = 0; k < 3000; k++) begin
      logic [5:0] op;
      int pick;
      pick = $urandom_range(0, 7);
      op = (pick < 6) ? ops[pick] : 6'($urandom);
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), op);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Main control FSM for the multicycle MIPS datapath, directly upstream of the ALU control unit. It decodes the instruction opcode over a sequence of states and drives every datapath enable and mux select. This includes the 2-bit `alu_op` that the ALU control unit combines with `funct` to select the ALU operation. Memory accesses stall on a ready handshake, and the block reports instruction retirement and illegal opcodes.

## Interface
- No parameters. Opcodes and state codes are fixed constants from the shared package.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `opcode` in 6: instruction[31:26] from the instruction register; sampled in DECODE.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `mem_to_reg`, `ir_write`, `reg_dst`, `reg_write`, `alu_src_a` out 1 each: datapath controls.
- `alu_src_b` out 2: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `alu_op` out 2: 00 = add, 01 = subtract, 10 = use funct. Feeds the ALU control unit.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_retired` out 1: one-cycle pulse in the final cycle of a legal instruction.
- `illegal_op` out 1: one-cycle pulse in DECODE when the opcode is unsupported.
- `state` out 4: current state code, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Outputs are Moore (decoded from the registered state), with two exceptions:
  - In FETCH, `ir_write` and `pc_write` equal `mem_ready`.
  - Write-enables are gated as listed below.
- Unlisted outputs are 0 in each state.
- State outputs:
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - MEM_WRITE: mem_write=1, i_or_d=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
- Transitions:
  - FETCH→DECODE when `mem_ready`; otherwise stay in FETCH.
  - DECODE→ lw/sw: MEM_ADDR; R: EXECUTE; beq: BRANCH; j: JUMP; addi: ADDI_EXEC; any other opcode: FETCH with `illegal_op`=1.
  - MEM_ADDR→MEM_READ (lw) or MEM_WRITE (sw), using the opcode latched in DECODE.
  - MEM_READ→MEM_WB when `mem_ready`; otherwise hold.
  - MEM_WRITE→FETCH when `mem_ready`; otherwise hold, keeping `mem_write` high.
  - EXECUTE→R_WB; ADDI_EXEC→ADDI_WB.
  - MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB → FETCH.
- `instr_retired`=1 in MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB, and in MEM_WRITE only in the cycle where `mem_ready`=1.
- The opcode is latched into a 6-bit register in DECODE. This makes the MEM_ADDR branch immune to IR changes.
- Unused state codes decode to all-zero outputs and return to FETCH on the next edge.

## Timing
- Reset: `rst_n`=0 at an edge sets state to FETCH and clears the latched opcode.
- While `rst_n`=0, the following are forced to 0 combinationally: pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read, instr_retired, illegal_op.
- Mux selects and `alu_op` during reset follow FETCH: 0 apart from alu_src_b=01.
- Reset mid-instruction abandons the instruction with no further write-enables.
- Cycles per instruction with zero wait states: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Each cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- PC increments exactly once per fetch, regardless of stall length.
- `mem_ready` is ignored in every state other than FETCH, MEM_READ and MEM_WRITE.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - 4-bit state codes (FETCH=0 … ADDI_WB=11);
  - 6-bit opcode constants;
  - `alu_op` codes (ADD=00, SUB=01, FUNCT=10), which are also used by the ALU control unit;
  - `alu_src_b` and `pc_source` select codes.
- One sub-module: `mc_ctrl_decode`, a purely combinational state-to-outputs decoder. The top level holds the state register, the opcode latch, next-state logic and reset gating.

## Test plan
- lw, mem_ready=1 always → states 0,1,2,3,4; reg_write and mem_to_reg=1 only in cycle 5; instr_retired pulses once; alu_op=00 throughout.
- R-type (opcode 000000) → EXECUTE drives alu_op=10, alu_src_a=1, alu_src_b=00; R_WB drives reg_dst=1, reg_write=1; 4 cycles total.
- sw with mem_ready low for 2 cycles in MEM_WRITE → mem_write high 3 consecutive cycles; instr_retired only on the third; then FETCH.
- beq then j → BRANCH drives alu_op=01, pc_write_cond=1, pc_source=01; JUMP drives pc_write=1, pc_source=10; 3 cycles each.
- opcode 111111 → illegal_op=1 for one DECODE cycle; next state FETCH; no reg_write or mem_write asserted.
- FETCH stall of 3 cycles, then `rst_n`=0 asserted in MEM_READ of a following lw → pc_write high for exactly 1 cycle; after the reset edge, state=0 and all write-enables stay 0 while reset is held.
